// File: rtl/reg_read_packetiser.sv
// Serialises one register read response (address + data) into a framed
// byte stream for the UART transmitter: address beat first, then data LSB first.
module reg_read_packetiser #(
    parameter logic [7:0]  SOURCE      = 8'h01,
    parameter logic [7:0]  DESTINATION = 8'h00,
    parameter int unsigned DATA_BYTES  = 4
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  logic        ipRdValid,
    input  logic [7:0]  ipRdAddress,
    input  logic [31:0] ipRdData,
    output logic        opRdReady,
    output logic        opTxValid,
    output logic        opTxSoP,
    output logic        opTxEoP,
    output logic [7:0]  opTxLength,
    output logic [7:0]  opTxData,
    output logic [7:0]  opTxSource,
    output logic [7:0]  opTxDestination,
    input  logic        ipTxReady
);

    localparam int unsigned BEAT_W    = 3;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BYTES);
    localparam logic [7:0]        PKT_LEN   = 8'(DATA_BYTES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q,  beat_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               valid_q, valid_d;
    logic               sop_q,   sop_d;
    logic               eop_q,   eop_d;
    logic [7:0]         len_q,   len_d;
    logic [7:0]         data_q,  data_d;

    // Next-state and next-beat content; the address is loaded straight into
    // the output data register on accept, so only the read data is kept.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rdata_d = rdata_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        len_d   = len_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (ipRdValid) begin
                    state_d = SEND;
                    beat_d  = '0;
                    rdata_d = ipRdData;
                    valid_d = 1'b1;
                    sop_d   = 1'b1;
                    eop_d   = 1'b0;
                    len_d   = PKT_LEN;
                    data_d  = ipRdAddress;
                end
            end
            SEND: begin
                if (valid_q && ipTxReady) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                    end else begin
                        // Beat k+1 carries data byte k
                        beat_d  = beat_q + 3'd1;
                        sop_d   = 1'b0;
                        eop_d   = ((beat_q + 3'd1) == LAST_BEAT);
                        data_d  = 8'(rdata_q >> {beat_q, 3'b000});
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

    assign opRdReady       = (state_q == IDLE) && ipReset;
    assign opTxValid       = valid_q;
    assign opTxSoP         = sop_q;
    assign opTxEoP         = eop_q;
    assign opTxLength      = len_q;
    assign opTxData        = data_q;
    assign opTxSource      = SOURCE;
    assign opTxDestination = DESTINATION;

endmodule

// File: tb/tb_reg_read_packetiser.sv
// Bench for reg_read_packetiser: table-driven packets with a beat scoreboard,
// plus hand sequences for busy, mid-packet reset and a 2-byte variant.
module tb_reg_read_packetiser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rd_valid, rd_ready, tx_ready;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        tx_valid, tx_sop, tx_eop;
    logic [7:0]  tx_len, tx_data, tx_src, tx_dst;

    logic        rd_valid2, rd_ready2, tx_ready2;
    logic [7:0]  rd_addr2;
    logic [31:0] rd_data2;
    logic        tx_valid2, tx_sop2, tx_eop2;
    logic [7:0]  tx_len2, tx_data2, tx_src2, tx_dst2;

    reg_read_packetiser dut (
        .ipClk(clk), .ipReset(rst_n), .ipRdValid(rd_valid), .ipRdAddress(rd_addr),
        .ipRdData(rd_data), .opRdReady(rd_ready), .opTxValid(tx_valid), .opTxSoP(tx_sop),
        .opTxEoP(tx_eop), .opTxLength(tx_len), .opTxData(tx_data), .opTxSource(tx_src),
        .opTxDestination(tx_dst), .ipTxReady(tx_ready)
    );

    reg_read_packetiser #(.DATA_BYTES(2)) dut2 (
        .ipClk(clk), .ipReset(rst_n), .ipRdValid(rd_valid2), .ipRdAddress(rd_addr2),
        .ipRdData(rd_data2), .opRdReady(rd_ready2), .opTxValid(tx_valid2), .opTxSoP(tx_sop2),
        .opTxEoP(tx_eop2), .opTxLength(tx_len2), .opTxData(tx_data2), .opTxSource(tx_src2),
        .opTxDestination(tx_dst2), .ipTxReady(tx_ready2)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int eop_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Expected beat: {data, sop, eop}
    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;
    beat_t exp_q[$];

    task automatic push_pkt(input logic [7:0] eb [5]);
        for (int k = 0; k < 5; k++)
            exp_q.push_back('{data: eb[k], sop: (k == 0), eop: (k == 4)});
    endtask

    // Monitor: pops the scoreboard on every transfer, checks holding under stall
    logic       stalled = 1'b0;
    logic [9:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("hold_stable", {22'd0, tx_valid, tx_sop, tx_eop, tx_data}, {22'd0, 1'b1, held[9:8], held[7:0]});
            if (tx_valid) begin
                chk("rd_ready_busy", 32'(rd_ready), 32'd0);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_data", 32'(tx_data), 32'(b.data));
                    chk("beat_sop",  32'(tx_sop),  32'(b.sop));
                    chk("beat_eop",  32'(tx_eop),  32'(b.eop));
                    chk("beat_len",  32'(tx_len),  32'd5);
                    if (tx_eop) eop_cyc = cyc;
                end
            end
            stalled = tx_valid && !tx_ready;
            held    = {tx_sop, tx_eop, tx_data};
        end
    end

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  exp[5];
        int          stall_beat;
        int          stall_len;
    } vec_t;
    vec_t vecs[5];

    task automatic wait_ready(input string name);
        int t = 0;
        while (!rd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rd_ready) fail_timeout(name);
    endtask

    // Drive one response and pace ipTxReady; the monitor checks the beats
    task automatic send_pkt(input vec_t v);
        rd_valid = 1'b1;
        rd_addr  = v.addr;
        rd_data  = v.data;
        wait_ready("accept_wait");
        @(posedge clk);
        push_pkt(v.exp);
        #1;
        rd_valid = 1'b0;
        chk("first_beat_latency", 32'(tx_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k == v.stall_beat) begin
                tx_ready = 1'b0;
                repeat (v.stall_len) @(posedge clk);
                #1;
                tx_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("valid_drop", 32'(tx_valid), 32'd0);
        chk("ready_after_eop", 32'(rd_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h12, 32'hA1B2C3D4, '{8'h12, 8'hD4, 8'hC3, 8'hB2, 8'hA1}, -1, 0};
        vecs[1] = '{8'h12, 32'hA1B2C3D4, '{8'h12, 8'hD4, 8'hC3, 8'hB2, 8'hA1},  2, 3};
        vecs[2] = '{8'h7E, 32'h01234567, '{8'h7E, 8'h67, 8'h45, 8'h23, 8'h01},  0, 2};
        vecs[3] = '{8'hFF, 32'h00000000, '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},  4, 1};
        vecs[4] = '{8'h00, 32'hFFFFFFFF, '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, -1, 0};

        // Reset with a response present; it must be ignored
        rst_n = 1'b0; tx_ready = 1'b1; rd_valid = 1'b1; rd_addr = 8'h99; rd_data = 32'h1;
        rd_valid2 = 1'b0; rd_addr2 = '0; rd_data2 = '0; tx_ready2 = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_valid", 32'(tx_valid), 32'd0);
            chk("rst_rd_ready", 32'(rd_ready), 32'd0);
        end
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_len",  32'(tx_len),  32'd0);
        chk("rst_sop_eop", {30'd0, tx_sop, tx_eop}, 32'd0);
        chk("rst_src",  32'(tx_src),  32'h01);
        chk("rst_dst",  32'(tx_dst),  32'h00);
        rd_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rd_ready_release", 32'(rd_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("idle_no_valid", 32'(tx_valid), 32'd0);

        foreach (vecs[i]) send_pkt(vecs[i]);

        // Busy: second response held while the first is in flight
        rd_valid = 1'b1; rd_addr = 8'h56; rd_data = 32'h11223344;
        wait_ready("busy_accept_a");
        @(posedge clk);
        push_pkt('{8'h56, 8'h44, 8'h33, 8'h22, 8'h11});
        #1;
        rd_addr = 8'h34; rd_data = 32'hCAFEF00D;
        @(negedge clk);
        wait_ready("busy_accept_b");
        chk("one_idle_gap", 32'(cyc), 32'(eop_cyc + 1));
        chk("idle_gap_valid", 32'(tx_valid), 32'd0);
        @(posedge clk);
        push_pkt('{8'h34, 8'h0D, 8'hF0, 8'hFE, 8'hCA});
        #1;
        rd_valid = 1'b0;
        chk("busy_b_latency", 32'(tx_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_b_done", 32'(tx_valid), 32'd0);

        // Reset after beat 1 has transferred
        rd_valid = 1'b1; rd_addr = 8'h77; rd_data = 32'h89ABCDEF;
        wait_ready("abort_accept");
        @(posedge clk);
        push_pkt('{8'h77, 8'hEF, 8'hCD, 8'hAB, 8'h89});
        #1;
        rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_beat2_shown", 32'(tx_data), 32'hCD);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_valid", 32'(tx_valid), 32'd0);
        chk("abort_no_eop", 32'(tx_eop), 32'd0);
        chk("abort_rd_ready", 32'(rd_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_back", 32'(rd_ready), 32'd1);
        send_pkt(vecs[2]);

        // DATA_BYTES=2 variant
        rd_valid2 = 1'b1; rd_addr2 = 8'h05; rd_data2 = 32'h0000BEEF;
        @(negedge clk);
        chk("db2_rd_ready", 32'(rd_ready2), 32'd1);
        @(posedge clk);
        #1;
        rd_valid2 = 1'b0;
        chk("db2_beat0", {tx_valid2, tx_sop2, tx_eop2, 13'd0, tx_len2, tx_data2}, {3'b110, 13'd0, 8'd3, 8'h05});
        @(posedge clk);
        #1;
        chk("db2_beat1", {tx_valid2, tx_sop2, tx_eop2, 13'd0, tx_len2, tx_data2}, {3'b100, 13'd0, 8'd3, 8'hEF});
        @(posedge clk);
        #1;
        chk("db2_beat2", {tx_valid2, tx_sop2, tx_eop2, 13'd0, tx_len2, tx_data2}, {3'b101, 13'd0, 8'd3, 8'hBE});
        @(posedge clk);
        #1;
        chk("db2_done", 32'(tx_valid2), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
